pci_arbiter: RTL and testbench
==============================

# pci_arbiter

Central round-robin arbiter for the shared PCI AD/CBE/Frame/Irdy bus. It sits beside the target logic and decides which of N initiators may drive the bus next: active-low Req/Gnt pairs, grant timeout, and a guaranteed one-cycle all-deasserted gap between grants. It watches Frame and Irdy to detect transaction start and bus idle; it never drives the bus itself.

## Interface
- N, 4: number of initiators (2..8)
- GNT_TIMEOUT, 16: cycles a grant may stand without Frame asserting (2..255)
- Clock  input  1  bus clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-high; one clock, reset asynchronous active-high
- Req  input  N  active-low request, bit i = initiator i
- Frame  input  1  active-low PCI Frame, monitored
- Irdy  input  1  active-low PCI Irdy, monitored
- Gnt  output  N  active-low grant, registered, at most one bit low
- Owner  output  clog2(N)  index of granted/owning initiator, valid when OwnerValid=1
- OwnerValid  output  1  high in GRANT and OWNED
- Timeout  output  1  one-cycle pulse when a grant is revoked for timeout

## Operation
- Bus idle = Frame==1 && Irdy==1, sampled at the edge.
- Round-robin pointer ptr (clog2(N) bits): search order ptr, ptr+1, … wrapping modulo N; first Req bit low wins. ptr resets to 0.
- States:
  - IDLE: Gnt all 1. If any Req low: latch winner w into Owner, Gnt[w]<=0, clear timer, -> GRANT. Else stay.
  - GRANT: Gnt[Owner]=0, timer increments each cycle.
    - Bus idle previously and Frame sampled 0 -> OWNED; ptr<=Owner+1 (mod N).
    - Else Req[Owner] sampled 1 (request withdrawn) -> GAP.
    - Else timer == GNT_TIMEOUT-1 -> GAP, Timeout=1 for that cycle, ptr<=Owner+1.
    - Frame-start has priority over withdrawal and timeout on the same edge.
  - OWNED: Gnt[Owner] held 0 while no other Req bit low; deasserted (1) on the edge after any other Req is sampled low and stays 1 thereafter (preemption; owner finishes via its latency timer). Bus idle sampled -> GAP.
  - GAP: Gnt all 1 for exactly one cycle -> IDLE.
- Frame falling while in IDLE or GAP (non-granted initiator, protocol error) is ignored; state unchanged.
- Req changes on non-owners never alter an in-flight grant except the OWNED preemption above.
- Timer: 8 bits, saturating, cleared on entry to GRANT.

## Timing
- Reset (async, immediate): Gnt=all 1, Owner=0, OwnerValid=0, Timeout=0, state IDLE, ptr=0, timer=0. Reset mid-transaction drops grant at once; no gap cycle needed after release.
- Request-to-grant latency from IDLE: Req sampled low at edge k -> Gnt low after edge k (visible cycle k+1).
- Re-grant latency after a bus release: bus-idle edge k -> GAP cycle k+1 -> IDLE decision edge k+2 -> new Gnt low after edge k+2. Minimum two all-high Gnt cycles between successive owners' grants counted from bus idle; never zero.
- Gnt, Owner, OwnerValid, Timeout are all registered; no combinational input->output path.
- Simultaneous requests: winner purely by ptr order.
- Owner changes only on the IDLE->GRANT edge.

## Test plan
- Single requester: Req=4'b1110 at cycle 2 -> Gnt=4'b1110 at cycle 3, Owner=0, OwnerValid=1; Frame=0 cycle 4 -> OWNED; Frame=1,Irdy=1 cycle 7 -> Gnt=4'b1111 cycle 8 (GAP), IDLE cycle 9.
- Round-robin fairness: Req=4'b0000 held, each grant completes a 2-data-phase transaction -> grant order 0,1,2,3,0 with exactly one grant low at any time and ≥1 all-high cycle between grants.
- Timeout: Req=4'b1101, Frame never asserted -> Gnt[1]=0 for 16 cycles, then Gnt=4'b1111 with Timeout=1 for one cycle; next grant goes to 2 if requested, else 1 again.
- Preemption: initiator 0 OWNED, Req[2] falls mid-transaction -> Gnt[0]=1 next cycle while Frame still 0; after bus idle, GAP then Gnt=4'b1011.
- Withdrawal: Gnt[3]=0, Req[3] returns 1 before Frame -> GAP, no Timeout, ptr unchanged.
- Async reset while OWNED: Reset=1 between edges -> Gnt=4'b1111, OwnerValid=0 immediately; after release with Req=4'b0110, first grant goes to initiator 0.

Source files
------------

// File: rtl/pci_arbiter.sv
// Central round-robin PCI bus arbiter: active-low Req/Gnt pairs, grant timeout,
// OWNED-state preemption and a guaranteed all-deasserted gap between grants.
module pci_arbiter #(
    parameter int N           = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N-1:0]         Req,
    input  logic                 Frame,
    input  logic                 Irdy,
    output logic [N-1:0]         Gnt,
    output logic [$clog2(N)-1:0] Owner,
    output logic                 OwnerValid,
    output logic                 Timeout
);
    localparam int W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        OWNED,
        GAP
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] ptr, ptr_next, ptr_after_owner;
    logic [W-1:0] owner_next, winner, cand;
    logic [N-1:0] gnt_next, owner_mask;
    logic [7:0]   timer, timer_next;
    logic         found, idle_q, bus_idle, others_req;
    logic         timeout_next, valid_next;

    assign bus_idle        = Frame && Irdy;
    assign owner_mask      = N'(1) << Owner;
    assign others_req      = |(~Req & ~owner_mask);
    assign ptr_after_owner = (Owner == W'(N - 1)) ? '0 : Owner + W'(1);

    // First low Req bit in the order ptr, ptr+1, ... wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = W'((32'(ptr) + i) % N);
            if (!found && !Req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        owner_next   = Owner;
        gnt_next     = Gnt;
        timer_next   = timer;
        timeout_next = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_next = '1;
                if (found) begin
                    owner_next = winner;
                    gnt_next   = ~(N'(1) << winner);
                    timer_next = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (timer != '1) begin
                    timer_next = timer + 8'd1;
                end
                // Frame start outranks withdrawal, which outranks timeout.
                if (idle_q && !Frame) begin
                    state_next = OWNED;
                    ptr_next   = ptr_after_owner;
                end else if (Req[Owner]) begin
                    state_next = GAP;
                    gnt_next   = '1;
                end else if (timer == 8'(GNT_TIMEOUT - 1)) begin
                    state_next   = GAP;
                    gnt_next     = '1;
                    timeout_next = 1'b1;
                    ptr_next     = ptr_after_owner;
                end
            end
            OWNED: begin
                // Once preempted, Gnt holds high because it is reloaded from itself.
                if (bus_idle) begin
                    state_next = GAP;
                    gnt_next   = '1;
                end else if (others_req) begin
                    gnt_next = '1;
                end
            end
            GAP: begin
                gnt_next   = '1;
                state_next = IDLE;
            end
            default: begin
                gnt_next   = '1;
                state_next = IDLE;
            end
        endcase
    end

    assign valid_next = (state_next == GRANT) || (state_next == OWNED);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= '0;
            Owner      <= '0;
            Gnt        <= '1;
            OwnerValid <= 1'b0;
            Timeout    <= 1'b0;
            timer      <= '0;
            idle_q     <= 1'b1;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            Owner      <= owner_next;
            Gnt        <= gnt_next;
            OwnerValid <= valid_next;
            Timeout    <= timeout_next;
            timer      <= timer_next;
            idle_q     <= bus_idle;
        end
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// Bench for pci_arbiter: directed protocol scenarios plus a randomized run,
// all compared cycle by cycle against a flag-based behavioural model.
module tb_pci_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic [N-1:0] Req   = '1;
    logic         Frame = 1'b1;
    logic         Irdy  = 1'b1;
    logic [N-1:0] Gnt;
    logic [1:0]   Owner;
    logic         OwnerValid;
    logic         Timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who holds the bus and what phase the grant is in.
    int           m_owner, m_rr, m_age;
    bit           m_granted, m_running, m_gap, m_preempt, m_was_idle, m_tmo;
    logic [N-1:0] exp_gnt;
    logic [1:0]   exp_owner;
    logic         exp_valid, exp_tmo;

    pci_arbiter #(.N(N), .GNT_TIMEOUT(TMO)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .Frame      (Frame),
        .Irdy       (Irdy),
        .Gnt        (Gnt),
        .Owner      (Owner),
        .OwnerValid (OwnerValid),
        .Timeout    (Timeout)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_owner = 0; m_rr = 0; m_age = 0;
        m_granted = 0; m_running = 0; m_gap = 0; m_preempt = 0;
        m_was_idle = 1; m_tmo = 0;
        exp_gnt = '1; exp_owner = '0; exp_valid = 1'b0; exp_tmo = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic f, input logic i);
        bit idle;
        bit others;
        bit found;
        int c;
        idle  = f && i;
        m_tmo = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_granted) begin
            if (m_was_idle && !f) begin
                m_granted = 0; m_running = 1; m_preempt = 0;
                m_rr = (m_owner + 1) % N;
            end else if (r[m_owner]) begin
                m_granted = 0; m_gap = 1;
            end else if (m_age == TMO - 1) begin
                m_granted = 0; m_gap = 1; m_tmo = 1;
                m_rr = (m_owner + 1) % N;
            end else begin
                m_age++;
            end
        end else if (m_running) begin
            others = 0;
            for (int k = 0; k < N; k++) if (k != m_owner && !r[k]) others = 1;
            if (idle) begin
                m_running = 0; m_gap = 1;
            end else if (others) begin
                m_preempt = 1;
            end
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (!found && !r[c]) begin
                    found = 1; m_owner = c; m_granted = 1; m_age = 0;
                end
            end
        end
        m_was_idle = idle;
        exp_gnt = '1;
        if (m_granted || (m_running && !m_preempt)) exp_gnt[m_owner] = 1'b0;
        exp_owner = 2'(m_owner);
        exp_valid = m_granted || m_running;
        exp_tmo   = m_tmo;
    endtask

    // Drive inputs just after an edge, step the model on the next edge, sample 1 ns later.
    task automatic cyc(input logic [N-1:0] r, input logic f, input logic i);
        Req = r; Frame = f; Irdy = i;
        @(posedge Clock);
        model_step(r, f, i);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({Gnt, Owner, OwnerValid, Timeout} !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_immediate: got gnt=%b owner=%0d valid=%b tmo=%b, want 1111/0/0/0",
                     Gnt, Owner, OwnerValid, Timeout);
        end
        @(posedge Clock); @(posedge Clock); #1;
        checks++;
        if ({Gnt, Owner, OwnerValid, Timeout} !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: got gnt=%b owner=%0d valid=%b tmo=%b, want 1111/0/0/0",
                     Gnt, Owner, OwnerValid, Timeout);
        end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [3:0] tf;
        logic [3:0] ti;
        int idx;
        tf = 4'b1100;
        ti = 4'b1001;
        for (int g = 0; g < 5; g++) begin
            idx = -1;
            for (int w = 0; w < 10 && idx < 0; w++) begin
                cyc('0, 1'b1, 1'b1);
                checks++;
                if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                    errors++;
                    $display("FAIL rr_wait g%0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                             g, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
                end
                for (int b = 0; b < N; b++) if (!Gnt[b]) idx = b;
            end
            checks++;
            if (idx != g % N) begin
                errors++;
                $display("FAIL rr_order grant %0d: got initiator %0d, want %0d", g, idx, g % N);
            end
            for (int t = 0; t < 4; t++) begin
                cyc('0, tf[t], ti[t]);
                checks++;
                if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                    errors++;
                    $display("FAIL rr_xfer g%0d t%0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                             g, t, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [N-1:0] sr [7];
        logic         sf [7];
        logic         si [7];
        logic [N-1:0] sg [7];
        logic         sv [7];
        sr = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111};
        sf = '{1, 1, 0, 0, 1, 1, 1};
        si = '{1, 1, 1, 0, 0, 1, 1};
        sg = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111};
        sv = '{0, 1, 1, 1, 1, 0, 0};
        for (int s = 0; s < 7; s++) begin
            cyc(sr[s], sf[s], si[s]);
            checks++;
            if ({Gnt, OwnerValid, Owner} !== {sg[s], sv[s], 2'd0}) begin
                errors++;
                $display("FAIL single_fixed step %0d: got gnt=%b valid=%b owner=%0d, want gnt=%b valid=%b owner=0",
                         s, Gnt, OwnerValid, Owner, sg[s], sv[s]);
            end
            checks++;
            if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                errors++;
                $display("FAIL single_model step %0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                         s, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
            end
        end
    endtask

    task automatic test_timeout();
        int held;
        logic seen_tmo;
        held = 0;
        seen_tmo = 1'b0;
        for (int w = 0; w < 40 && !seen_tmo; w++) begin
            cyc(4'b1101, 1'b1, 1'b1);
            checks++;
            if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                errors++;
                $display("FAIL timeout_model w%0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                         w, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
            end
            if (Gnt == 4'b1101) held++;
            if (Timeout) seen_tmo = 1'b1;
        end
        checks++;
        if (!seen_tmo || held != TMO || Gnt !== 4'b1111) begin
            errors++;
            $display("FAIL timeout_len: got held=%0d tmo_seen=%b gnt=%b, want held=%0d tmo_seen=1 gnt=1111",
                     held, seen_tmo, Gnt, TMO);
        end
        // Initiator 2 requests alongside 1; the pointer moved past 1 so 2 wins.
        for (int s = 0; s < 2; s++) begin
            cyc(4'b1001, 1'b1, 1'b1);
            checks++;
            if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                errors++;
                $display("FAIL timeout_next_model s%0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                         s, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
            end
        end
        checks++;
        if (Gnt !== 4'b1011 || Timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next_grant: got gnt=%b tmo=%b, want gnt=1011 tmo=0", Gnt, Timeout);
        end
        cyc(4'b1111, 1'b1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1);
    endtask

    task automatic test_preempt();
        logic [N-1:0] pr [7];
        logic         pf [7];
        logic         pi [7];
        pr = '{4'b1110, 4'b1110, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        pf = '{1, 0, 0, 1, 1, 1, 1};
        pi = '{1, 1, 0, 0, 1, 1, 1};
        for (int s = 0; s < 7; s++) begin
            cyc(pr[s], pf[s], pi[s]);
            checks++;
            if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                errors++;
                $display("FAIL preempt_model step %0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                         s, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
            end
            if (s == 2) begin
                checks++;
                if ({Gnt, OwnerValid, Owner} !== {4'b1111, 1'b1, 2'd0}) begin
                    errors++;
                    $display("FAIL preempt_drop: got gnt=%b valid=%b owner=%0d, want gnt=1111 valid=1 owner=0",
                             Gnt, OwnerValid, Owner);
                end
            end
        end
        checks++;
        if (Gnt !== 4'b1011) begin
            errors++;
            $display("FAIL preempt_regrant: got gnt=%b, want 1011", Gnt);
        end
        cyc(4'b1111, 1'b1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1);
    endtask

    task automatic test_withdraw();
        logic [N-1:0] wr [4];
        wr = '{4'b0111, 4'b1111, 4'b1111, 4'b0000};
        for (int s = 0; s < 4; s++) begin
            cyc(wr[s], 1'b1, 1'b1);
            checks++;
            if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                errors++;
                $display("FAIL withdraw_model step %0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                         s, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
            end
            if (s == 1) begin
                checks++;
                if (Gnt !== 4'b1111 || Timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL withdraw_gap: got gnt=%b tmo=%b, want gnt=1111 tmo=0", Gnt, Timeout);
                end
            end
        end
        // Pointer stood at 1 before the withdrawn grant to 3 and must not have moved.
        checks++;
        if (Gnt !== 4'b1101) begin
            errors++;
            $display("FAIL withdraw_ptr: got gnt=%b, want 1101", Gnt);
        end
        cyc(4'b1111, 1'b1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        cyc(4'b1110, 1'b1, 1'b1);
        cyc(4'b1110, 1'b0, 1'b1);
        cyc(4'b1110, 1'b0, 1'b0);
        checks++;
        if (Gnt !== 4'b1110 || OwnerValid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: got gnt=%b valid=%b, want gnt=1110 valid=1", Gnt, OwnerValid);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Gnt, OwnerValid, Timeout} !== {4'b1111, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: got gnt=%b valid=%b tmo=%b, want 1111/0/0", Gnt, OwnerValid, Timeout);
        end
        Req = 4'b0110; Frame = 1'b1; Irdy = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
        cyc(4'b0110, 1'b1, 1'b1);
        checks++;
        if ({Gnt, Owner, OwnerValid} !== {4'b1110, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL areset_first_grant: got gnt=%b owner=%0d valid=%b, want gnt=1110 owner=0 valid=1",
                     Gnt, Owner, OwnerValid);
        end
        cyc(4'b1111, 1'b1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] prev_gnt;
        int highs;
        r = '1;
        prev_gnt = '1;
        highs = 2;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
            cyc(r, ($urandom_range(9) >= 4), ($urandom_range(1) == 1));
            checks++;
            if ({Gnt, Owner, OwnerValid, Timeout} !== {exp_gnt, exp_owner, exp_valid, exp_tmo}) begin
                errors++;
                $display("FAIL random_model n%0d: got gnt=%b owner=%0d valid=%b tmo=%b, want gnt=%b owner=%0d valid=%b tmo=%b",
                         n, Gnt, Owner, OwnerValid, Timeout, exp_gnt, exp_owner, exp_valid, exp_tmo);
            end
            checks++;
            if ($countones(~Gnt) > 1) begin
                errors++;
                $display("FAIL random_onehot n%0d: got gnt=%b, want at most one low bit", n, Gnt);
            end
            if (Gnt != '1) begin
                checks++;
                if (prev_gnt == '1 && highs < 2) begin
                    errors++;
                    $display("FAIL random_gap n%0d: got %0d all-high cycles, want >= 2", n, highs);
                end else if (prev_gnt != '1 && Gnt !== prev_gnt) begin
                    errors++;
                    $display("FAIL random_switch n%0d: got gnt %b -> %b, want no direct handover", n, prev_gnt, Gnt);
                end
                highs = 0;
            end else begin
                highs++;
            end
            prev_gnt = Gnt;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_preempt();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
